ppd_ctrl_seq: RTL and testbench

- Control/status sequencer for the lms_dsp packet-presence-detector (PPD) datapath.
- Takes 32-bit memory-mapped writes and reads from the host-side CSR bus and drives all ppd_cfg_* inputs of the DSP.
- Sequences enable as clear-running-sums → settle → run, so the detector never runs on stale sums.
- Captures the three ppd_debug_* counters atomically for readout.

---
 rtl/ppd_ctrl_seq.sv | 193 +++++++++++++++++++
 tb/tb_ppd_ctrl_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppd_ctrl_seq.sv
// rtl/ppd_ctrl_seq.sv - PPD control/status sequencer: CSR bus, clear/settle/run enable sequencing, debug snapshots.
// Optional packet counter at address 7 is built only when PPD_CTRL_PKT_CNT_EN is defined.
module ppd_ctrl_seq #(
    parameter int          CLR_CYCLES    = 16,
    parameter int          SETTLE_CYCLES = 1024,
    parameter logic [7:0]  THRESH_RST    = 8'd16,
    parameter logic [15:0] PASSLEN_RST   = 16'd256
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        ppd_cfg_enable_ppd,
    output logic        ppd_cfg_enable_fir,
    output logic        ppd_cfg_clear_rs,
    output logic [7:0]  ppd_cfg_threshold,
    output logic [15:0] ppd_cfg_passthrough_len,
    input  logic [31:0] ppd_debug_count,
    input  logic [31:0] ppd_debug_long_sum,
    input  logic [31:0] ppd_debug_short_sum,
    input  logic        fifo_out_wrreq,
    output logic        busy
);

    localparam int MAX_CYCLES = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] CLR_LOAD    = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          en_ppd_req;
    logic [7:0]    thresh_shadow;
    logic [15:0]   passlen_shadow;
    logic [31:0]   snap_count;
    logic [31:0]   snap_long;
    logic [31:0]   snap_short;
    logic [31:0]   pkt_cnt;
    logic [31:0]   rd_mux;
    logic          ctrl_wr;
    logic          req_eff;
    logic          restart_eff;
    logic          enter_clear;

    // The sequencer reacts to a CTRL write in the same cycle it is presented,
    // so the CLEAR phase starts on the edge that also captures the register.
    always_comb begin
        ctrl_wr     = avs_write && (avs_address == 3'd0);
        req_eff     = ctrl_wr ? avs_writedata[0] : en_ppd_req;
        restart_eff = ctrl_wr && avs_writedata[2];
        enter_clear = req_eff && ((state == IDLE) ||
                      (((state == SETTLE) || (state == RUN)) && restart_eff));
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state              <= IDLE;
            cnt                <= '0;
            ppd_cfg_clear_rs   <= 1'b0;
            ppd_cfg_enable_ppd <= 1'b0;
            busy               <= 1'b0;
        end else if (!req_eff) begin
            state              <= IDLE;
            cnt                <= '0;
            ppd_cfg_clear_rs   <= 1'b0;
            ppd_cfg_enable_ppd <= 1'b0;
            busy               <= 1'b0;
        end else if (enter_clear) begin
            state              <= CLEAR;
            cnt                <= CLR_LOAD;
            ppd_cfg_clear_rs   <= 1'b1;
            ppd_cfg_enable_ppd <= 1'b0;
            busy               <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (restart_eff) begin
                        cnt <= CLR_LOAD;
                    end else if (cnt == '0) begin
                        state            <= SETTLE;
                        cnt              <= SETTLE_LOAD;
                        ppd_cfg_clear_rs <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state              <= RUN;
                        ppd_cfg_enable_ppd <= 1'b1;
                        busy               <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Shadows reach the DSP only while idle or when a fresh clear begins.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            en_ppd_req              <= 1'b0;
            ppd_cfg_enable_fir      <= 1'b0;
            thresh_shadow           <= THRESH_RST;
            passlen_shadow          <= PASSLEN_RST;
            ppd_cfg_threshold       <= THRESH_RST;
            ppd_cfg_passthrough_len <= PASSLEN_RST;
        end else begin
            if (ctrl_wr) begin
                en_ppd_req         <= avs_writedata[0];
                ppd_cfg_enable_fir <= avs_writedata[1];
            end
            if (avs_write && (avs_address == 3'd1)) thresh_shadow  <= avs_writedata[7:0];
            if (avs_write && (avs_address == 3'd2)) passlen_shadow <= avs_writedata[15:0];
            if ((state == IDLE) || enter_clear) begin
                ppd_cfg_threshold       <= thresh_shadow;
                ppd_cfg_passthrough_len <= passlen_shadow;
            end
        end
    end

`ifdef PPD_CTRL_PKT_CNT_EN
    logic wrreq_d;
    logic unused_bits;
    assign unused_bits = ^avs_writedata[31:16];

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wrreq_d <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            wrreq_d <= fifo_out_wrreq;
            if (avs_write && (avs_address == 3'd7)) pkt_cnt <= '0;
            else if ((state == RUN) && fifo_out_wrreq && !wrreq_d) pkt_cnt <= pkt_cnt + 1'b1;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{avs_writedata[31:16], fifo_out_wrreq};
    assign pkt_cnt     = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            3'd0: rd_mux = {30'd0, ppd_cfg_enable_fir, en_ppd_req};
            3'd1: rd_mux = {24'd0, thresh_shadow};
            3'd2: rd_mux = {16'd0, passlen_shadow};
            3'd3: rd_mux = {29'd0, busy, state};
            3'd4: rd_mux = ppd_debug_count;
            3'd5: rd_mux = snap_long;
            3'd6: rd_mux = snap_short;
            3'd7: rd_mux = pkt_cnt;
            default: rd_mux = '0;
        endcase
    end

    // Reading SNAP_COUNT latches all three counters together; the count itself is returned live.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            snap_count        <= '0;
            snap_long         <= '0;
            snap_short        <= '0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) avs_readdata <= rd_mux;
            if (avs_read && (avs_address == 3'd4)) begin
                snap_count <= ppd_debug_count;
                snap_long  <= ppd_debug_long_sum;
                snap_short <= ppd_debug_short_sum;
            end
        end
    end

    logic unused_snap;
    assign unused_snap = ^snap_count;

endmodule

// File: tb/tb_ppd_ctrl_seq.sv
// tb/tb_ppd_ctrl_seq.sv - Self-checking bench for ppd_ctrl_seq with CLR_CYCLES=4, SETTLE_CYCLES=8.
module tb_ppd_ctrl_seq;
    localparam int CLR = 4;
    localparam int SET = 8;
`ifdef PPD_CTRL_PKT_CNT_EN
    localparam logic [31:0] PKT3 = 32'd3;
`else
    localparam logic [31:0] PKT3 = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  addr;
    logic        write;
    logic [31:0] wd;
    logic        read;
    logic [31:0] rdata;
    logic        rdv;
    logic        en_ppd, en_fir, clear_rs, busy, wrreq;
    logic [7:0]  thr;
    logic [15:0] plen;
    logic [31:0] dbg_cnt, dbg_long, dbg_short;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] exp;
        string       nm;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [2:0]  a;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    ppd_ctrl_seq #(.CLR_CYCLES(CLR), .SETTLE_CYCLES(SET)) dut (
        .clk_clk(clk), .reset_reset(rst),
        .avs_address(addr), .avs_write(write), .avs_writedata(wd),
        .avs_read(read), .avs_readdata(rdata), .avs_readdatavalid(rdv),
        .ppd_cfg_enable_ppd(en_ppd), .ppd_cfg_enable_fir(en_fir),
        .ppd_cfg_clear_rs(clear_rs), .ppd_cfg_threshold(thr),
        .ppd_cfg_passthrough_len(plen),
        .ppd_debug_count(dbg_cnt), .ppd_debug_long_sum(dbg_long),
        .ppd_debug_short_sum(dbg_short),
        .fifo_out_wrreq(wrreq), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (!rst && rdv) begin
            if (sb.size() == 0) chk("unexpected_readdatavalid", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk(e.nm, rdata, e.exp);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; wd = d; write = 1'b1;
        step();
        write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
        addr = a; read = 1'b1;
        sb.push_back('{exp, nm});
        step();
        read = 1'b0;
        @(negedge clk);
        chk({nm, "_rdv"}, {31'd0, rdv}, 32'd1);
        step();
    endtask

    // Called in the cycle after the CTRL write that starts a clear.
    task automatic check_seq(input logic [7:0] exp_thr, input string tag);
        for (int i = 1; i <= CLR + SET + 2; i++) begin
            @(negedge clk);
            chk($sformatf("%s_clear_rs_c%0d", tag, i), {31'd0, clear_rs}, {31'd0, i <= CLR});
            chk($sformatf("%s_busy_c%0d", tag, i), {31'd0, busy}, {31'd0, i <= CLR + SET});
            chk($sformatf("%s_enable_c%0d", tag, i), {31'd0, en_ppd}, {31'd0, i > CLR + SET});
            chk($sformatf("%s_thresh_c%0d", tag, i), {24'd0, thr}, {24'd0, exp_thr});
            step();
        end
    endtask

    task automatic bursts(input int n);
        for (int b = 0; b < n; b++) begin
            wrreq = 1'b1;
            step(5);
            wrreq = 1'b0;
            step(3);
        end
    endtask

    initial begin
        tbl[0] = '{3'd1, 32'hFFFF_FF5A, 32'h0000_005A};
        tbl[1] = '{3'd2, 32'h1234_ABCD, 32'h0000_ABCD};
        tbl[2] = '{3'd0, 32'h0000_0002, 32'h0000_0002};
        tbl[3] = '{3'd0, 32'h0000_0004, 32'h0000_0000};
        tbl[4] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[5] = '{3'd5, 32'h0000_0007, 32'h0000_0000};
        tbl[6] = '{3'd7, 32'h0000_0009, 32'h0000_0000};
        tbl[7] = '{3'd1, 32'h0000_0010, 32'h0000_0010};
        tbl[8] = '{3'd2, 32'h0000_0100, 32'h0000_0100};

        rst = 1'b1; addr = '0; write = 1'b0; wd = '0; read = 1'b0; wrreq = 1'b0;
        dbg_cnt = '0; dbg_long = '0; dbg_short = '0;
        step(3);
        @(negedge clk);
        chk("rst_enable_ppd", {31'd0, en_ppd}, 32'd0);
        chk("rst_enable_fir", {31'd0, en_fir}, 32'd0);
        chk("rst_clear_rs", {31'd0, clear_rs}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_thresh", {24'd0, thr}, 32'h10);
        chk("rst_passlen", {16'd0, plen}, 32'h100);
        chk("rst_rdv", {31'd0, rdv}, 32'd0);
        chk("rst_readdata", rdata, 32'd0);
        step();
        rst = 1'b0;
        rd(3'd1, 32'h10, "rst_rd_thresh");
        rd(3'd2, 32'h100, "rst_rd_passlen");
        rd(3'd3, 32'h0, "rst_rd_status");

        for (int i = 0; i < 9; i++) begin
            wr(tbl[i].a, tbl[i].wdat);
            rd(tbl[i].a, tbl[i].exp, $sformatf("tbl%0d_a%0d", i, tbl[i].a));
        end

        wr(3'd0, 32'h2);
        @(negedge clk);
        chk("fir_pass", {31'd0, en_fir}, 32'd1);
        chk("fir_no_ppd", {31'd0, en_ppd}, 32'd0);
        step();
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h22);
        step();
        @(negedge clk);
        chk("idle_thresh_follow", {24'd0, thr}, 32'h22);
        step();
        wr(3'd1, 32'h10);
        step(2);

        wr(3'd0, 32'h1);
        check_seq(8'h10, "seq1");
        rd(3'd3, 32'h3, "status_run");

        wr(3'd1, 32'h40);
        step(2);
        @(negedge clk);
        chk("run_thresh_hold", {24'd0, thr}, 32'h10);
        step();
        wr(3'd0, 32'h5);
        check_seq(8'h40, "restart_run");
        rd(3'd3, 32'h3, "status_run2");

        wr(3'd0, 32'h4);
        @(negedge clk);
        chk("abort_prio_busy", {31'd0, busy}, 32'd0);
        chk("abort_prio_enable", {31'd0, en_ppd}, 32'd0);
        chk("abort_prio_clear", {31'd0, clear_rs}, 32'd0);
        step();
        rd(3'd3, 32'h0, "status_abort");

        wr(3'd0, 32'h1);
        step();
        @(negedge clk);
        chk("clear_c2", {31'd0, clear_rs}, 32'd1);
        wr(3'd0, 32'h0);
        @(negedge clk);
        chk("abort_clear_rs", {31'd0, clear_rs}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        step();
        rd(3'd3, 32'h0, "status_abort_clear");
        wr(3'd0, 32'h1);
        check_seq(8'h40, "seq2");

        wr(3'd0, 32'h0);
        step();
        wr(3'd0, 32'h1);
        step();
        wr(3'd0, 32'h5);
        check_seq(8'h40, "restart_clear");

        bursts(3);
        rd(3'd7, PKT3, "pkt_run");
        wr(3'd0, 32'h0);
        step(2);
        bursts(2);
        rd(3'd7, PKT3, "pkt_idle_hold");
        wr(3'd7, 32'h0);
        rd(3'd7, 32'h0, "pkt_clear");

        dbg_cnt = 32'hA; dbg_long = 32'hB; dbg_short = 32'hC;
        rd(3'd4, 32'hA, "snap_count");
        dbg_cnt = 32'h1; dbg_long = 32'h2; dbg_short = 32'h3;
        rd(3'd5, 32'hB, "snap_long");
        rd(3'd6, 32'hC, "snap_short");
        rd(3'd4, 32'h1, "snap_count2");
        rd(3'd5, 32'h2, "snap_long2");

        addr = 3'd1; wd = 32'h77; write = 1'b1; read = 1'b1;
        sb.push_back('{32'h40, "rw_same_old"});
        step();
        write = 1'b0; read = 1'b0;
        step();
        rd(3'd1, 32'h77, "rw_same_new");

        wr(3'd0, 32'h1);
        step(2);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_clear", {31'd0, clear_rs}, 32'd0);
        chk("midrst_thresh", {24'd0, thr}, 32'h10);
        step();
        rst = 1'b0;
        rd(3'd1, 32'h10, "midrst_rd_thresh");
        rd(3'd3, 32'h0, "midrst_status");

        step(2);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
